// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: the controller drives the
// request side (master), the subtractor drives status and result (slave).
interface serial_subtractor_if;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       Borrow_in;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       Borrow_out;
  logic       zero;
  logic       ovf;

  modport master (
    output start, x, y, Borrow_in,
    input  busy, done, d, Borrow_out, zero, ovf
  );

  modport slave (
    input  start, x, y, Borrow_in,
    output busy, done, d, Borrow_out, zero, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial 8-bit subtractor: x - y - Borrow_in, one bit per clock, LSB first,
// with a single borrow flop and a start/busy/done handshake.
module serial_subtractor (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

  state_e     state_q;
  logic [7:0] xs_q;
  logic [7:0] ys_q;
  logic [7:0] d_q;
  logic       b_q;
  logic [2:0] cnt_q;
  logic       x7_q;
  logic       y7_q;
  logic       busy_q;
  logic       done_q;
  logic       bout_q;
  logic       zero_q;
  logic       ovf_q;

  logic       xi;
  logic       yi;
  logic       diff;
  logic       b_d;
  logic [7:0] d_d;

  // Signed overflow of a subtraction: operands of differing sign and a result
  // whose sign disagrees with the minuend.
  function automatic logic sub_ovf(input logic x_msb, input logic y_msb, input logic d_msb);
    return (x_msb != y_msb) && (d_msb != x_msb);
  endfunction

  always_comb begin
    xi   = xs_q[0];
    yi   = ys_q[0];
    diff = xi ^ yi ^ b_q;
    b_d  = (~xi & yi) | (~(xi ^ yi) & b_q);
    d_d  = {diff, d_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xs_q    <= 8'h00;
      ys_q    <= 8'h00;
      d_q     <= 8'h00;
      b_q     <= 1'b0;
      cnt_q   <= 3'd0;
      x7_q    <= 1'b0;
      y7_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            xs_q    <= bus.x;
            ys_q    <= bus.y;
            b_q     <= bus.Borrow_in;
            x7_q    <= bus.x[7];
            y7_q    <= bus.y[7];
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= SUB;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SUB: begin
          xs_q  <= {1'b0, xs_q[7:1]};
          ys_q  <= {1'b0, ys_q[7:1]};
          b_q   <= b_d;
          d_q   <= d_d;
          cnt_q <= cnt_q + 3'd1;
          // Flags are taken from the final shift so they are valid in the DONE cycle.
          if (cnt_q == 3'd7) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bout_q  <= b_d;
            zero_q  <= (d_d == 8'h00);
            ovf_q   <= sub_ovf(x7_q, y7_q, d_d[7]);
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.d          = d_q;
  assign bus.Borrow_out = bout_q;
  assign bus.zero       = zero_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic/timing model plus
// directed vectors with hand-computed results and a random sweep.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   ops_done = 0;
  int   t_acc = 0;
  int   t_done = 0;
  bit   chk_en = 1'b0;

  serial_subtractor_if bus ();

  serial_subtractor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       z;
    logic       ov;
  } res_t;

  // Plain integer arithmetic: unsigned difference/borrow and signed range check.
  function automatic res_t ref_sub(input logic [7:0] x, input logic [7:0] y, input logic b);
    res_t r;
    int   u;
    int   s;
    u    = int'(x) - int'(y) - int'(b);
    s    = int'($signed(x)) - int'($signed(y)) - int'(b);
    r.d  = u[7:0];
    r.bo = (u < 0);
    r.z  = (u[7:0] == 8'h00);
    r.ov = (s > 127) || (s < -128);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle-level model of the handshake and held result.
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  int   m_left = 0;
  res_t m_res = '0;
  res_t m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_res  = '0;
    end else if (!m_busy && bus.start) begin
      m_pend = ref_sub(bus.x, bus.y, bus.Borrow_in);
      m_busy = 1'b1;
      m_done = 1'b0;
      m_left = 8;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("done", int'(bus.done), int'(m_done));
      if (bus.done === 1'b1) done_cnt++;
      if (!m_busy) begin
        chk("d", int'(bus.d), int'(m_res.d));
        chk("borrow_out", int'(bus.Borrow_out), int'(m_res.bo));
        chk("zero", int'(bus.zero), int'(m_res.z));
        chk("ovf", int'(bus.ovf), int'(m_res.ov));
      end
    end
  end

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic b);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.x         = x;
    bus.y         = y;
    bus.Borrow_in = b;
    @(posedge clk);
    #1;
    t_acc     = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      t_done = cyc;
      ops_done++;
    end else begin
      chk({name, "_timeout"}, 0, 1);
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic b, input logic [7:0] ed, input logic ebo,
                        input logic ez, input logic eov);
    res_t r;
    r = ref_sub(x, y, b);
    chk({name, "_model_d"}, int'(r.d), int'(ed));
    chk({name, "_model_bo"}, int'(r.bo), int'(ebo));
    chk({name, "_model_ov"}, int'(r.ov), int'(eov));
    start_op(x, y, b);
    wait_done(name);
    chk({name, "_d"}, int'(bus.d), int'(ed));
    chk({name, "_bo"}, int'(bus.Borrow_out), int'(ebo));
    chk({name, "_zero"}, int'(bus.zero), int'(ez));
    chk({name, "_ovf"}, int'(bus.ovf), int'(eov));
  endtask

  initial begin
    int c1;
    int aborted_dones;
    bus.start     = 1'b0;
    bus.x         = 8'h00;
    bus.y         = 8'h00;
    bus.Borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_d", int'(bus.d), 0);
    chk("rst_flags", int'({bus.Borrow_out, bus.zero, bus.ovf}), 0);

    run_op("sub50_30", 8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0);
    chk("latency", t_done - t_acc, 8);
    run_op("sub30_50", 8'h30, 8'h50, 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0);
    run_op("sub0_0_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("sub80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    run_op("sub7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_d", int'(bus.d), 8'h80);
    chk("hold_ovf", int'(bus.ovf), 1);

    // Back-to-back: start stays high through the first DONE cycle.
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x = 8'hA5; bus.y = 8'hA5; bus.Borrow_in = 1'b0;
    @(posedge clk);
    #1;
    bus.x = 8'h10; bus.y = 8'h01;
    wait_done("b2b_first");
    c1 = t_done;
    chk("b2b_first_d", int'(bus.d), 8'h00);
    chk("b2b_first_zero", int'(bus.zero), 1);
    chk("b2b_first_bo", int'(bus.Borrow_out), 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("b2b_second");
    chk("b2b_spacing", t_done - c1, 9);
    chk("b2b_second_d", int'(bus.d), 8'h0F);

    // Start during SUB must not re-latch operands.
    start_op(8'h50, 8'h30, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.x = 8'hFF; bus.y = 8'h00;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignore_start");
    chk("ignore_start_d", int'(bus.d), 8'h20);

    // Reset mid-operation.
    start_op(8'h50, 8'h30, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_d", int'(bus.d), 0);
    chk("abort_flags", int'({bus.Borrow_out, bus.zero, bus.ovf}), 0);
    aborted_dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) aborted_dones++;
    end
    chk("abort_no_done", aborted_dones, 0);

    for (int n = 0; n < 1000; n++) begin
      res_t r;
      logic [7:0] rx;
      logic [7:0] ry;
      logic       rb;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rb = 1'($urandom_range(0, 1));
      r  = ref_sub(rx, ry, rb);
      start_op(rx, ry, rb);
      wait_done("rand");
      chk("rand_d", int'(bus.d), int'(r.d));
      chk("rand_bo", int'(bus.Borrow_out), int'(r.bo));
    end

    repeat (3) @(negedge clk);
    chk("done_pulse_count", done_cnt, ops_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
